// File: rtl/tdm_demux4_b4_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexer.
// Holds the framing state enum and the channel/slot geometry.
package tdm_pkg;

    localparam int N_CH      = 4;
    localparam int SLOT_W    = 2;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } tdm_state_t;

endpackage

// File: rtl/tdm_demux4_b4_chan_reg.sv
// One-entry valid/ready holding register for a single output channel.
// A load wins over a drain, so a same-cycle drain and load refills without a bubble.
module tdm_chan_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tdm_demux4_b4.sv
// Receive end of the 4-slot TDM link: frame lock FSM, slot tracking and
// per-slot delivery into four valid/ready channel registers.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   HUNT   | waiting for an in_sof beat; everything else is dropped
//   CHECK  | counting well-formed frames, nothing delivered
//   LOCKED | slot k goes to channel k; framing mismatch drops back to HUNT
module tdm_demux4_b4
    import tdm_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [SLOT_W-1:0] S,
    output logic [WIDTH-1:0]  D0,
    output logic [WIDTH-1:0]  D1,
    output logic [WIDTH-1:0]  D2,
    output logic [WIDTH-1:0]  D3,
    output logic [N_CH-1:0]   D_valid,
    input  logic [N_CH-1:0]   D_ready,
    output logic              locked,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int GC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

    tdm_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [GC_W-1:0]   good_q, good_d;
    logic              frame_done_d, sync_err_d;
    logic              acc, mism;
    logic [N_CH-1:0]   load;
    logic [WIDTH-1:0]  d_q [N_CH];

    // Once locked, only the channel the next beat targets can stall the link.
    assign in_ready = (state_q == LOCKED) ? (!D_valid[slot_q] | D_ready[slot_q]) : 1'b1;
    assign acc      = in_valid & in_ready;
    assign mism     = acc & (in_sof != (slot_q == '0));
    assign locked   = (state_q == LOCKED);
    assign S        = slot_q;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        good_d       = good_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        case (state_q)
            HUNT: begin
                if (acc && in_sof) begin
                    state_d = CHECK;
                    slot_d  = SLOT_W'(1);
                    good_d  = '0;
                end
            end
            CHECK: begin
                if (mism) begin
                    state_d = HUNT;
                    slot_d  = '0;
                end else if (acc) begin
                    slot_d = slot_q + 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        good_d = good_q + 1'b1;
                        if (good_q == GC_W'(LOCK_FRAMES - 1)) state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (mism) begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                    slot_d     = '0;
                end else if (acc) begin
                    slot_d       = slot_q + 1'b1;
                    frame_done_d = (slot_q == LAST_SLOT);
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            good_q     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            good_q     <= good_d;
            frame_done <= frame_done_d;
            sync_err   <= sync_err_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        assign load[k] = acc & locked & !mism & (slot_q == SLOT_W'(k));

        tdm_chan_reg #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .data  (in_data),
            .ready (D_ready[k]),
            .valid (D_valid[k]),
            .q     (d_q[k])
        );
    end

    assign D0 = d_q[0];
    assign D1 = d_q[1];
    assign D2 = d_q[2];
    assign D3 = d_q[3];

endmodule

// File: tb/tb_tdm_demux4_b4.sv
// Directed bench for tdm_demux4_b4: a slot/frame-level reference model checked
// every cycle, plus literal expectations at the points of interest.
module tb_tdm_demux4_b4;

    localparam int WIDTH = 4;
    localparam int LF    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic             in_ready;
    logic [1:0]       S;
    logic [WIDTH-1:0] D0, D1, D2, D3;
    logic [3:0]       D_valid;
    logic [3:0]       D_ready = 4'hF;
    logic             locked, frame_done, sync_err;

    int n_checks = 0;
    int n_err    = 0;
    int fd_count = 0;
    bit started  = 1'b0;

    // reference model: 0 = hunting, 1 = verifying frames, 2 = locked
    int               m_state, m_slot, m_good;
    logic [WIDTH-1:0] m_d [4];
    bit               m_v [4];
    bit               m_fd, m_se;

    tdm_demux4_b4 #(.WIDTH(WIDTH), .LOCK_FRAMES(LF)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .S          (S),
        .D0         (D0),
        .D1         (D1),
        .D2         (D2),
        .D3         (D3),
        .D_valid    (D_valid),
        .D_ready    (D_ready),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        if (m_state != 2) return 1'b1;
        return !m_v[m_slot] || D_ready[m_slot];
    endfunction

    function automatic logic [3:0] m_vvec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_v[k];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_slot = 0; m_good = 0; m_fd = 0; m_se = 0;
            for (int k = 0; k < 4; k++) begin m_d[k] = '0; m_v[k] = 0; end
        end else begin
            bit rdy, acc, sof_ok;
            rdy    = m_ready();
            acc    = in_valid && rdy;
            sof_ok = (in_sof == (m_slot == 0));
            m_fd = 0; m_se = 0;
            for (int k = 0; k < 4; k++) if (m_v[k] && D_ready[k]) m_v[k] = 0;
            if (acc) begin
                case (m_state)
                    0: if (in_sof) begin m_state = 1; m_slot = 1; m_good = 0; end
                    1: if (!sof_ok) begin
                           m_state = 0; m_slot = 0;
                       end else begin
                           if (m_slot == 3) begin
                               m_good++;
                               if (m_good == LF) m_state = 2;
                           end
                           m_slot = (m_slot + 1) % 4;
                       end
                    default: if (!sof_ok) begin
                           m_se = 1; m_state = 0; m_slot = 0;
                       end else begin
                           m_d[m_slot] = in_data;
                           m_v[m_slot] = 1;
                           if (m_slot == 3) m_fd = 1;
                           m_slot = (m_slot + 1) % 4;
                       end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmp_in_ready", in_ready, m_ready());
            check("cmp_S", S, m_slot);
            check("cmp_locked", locked, m_state == 2);
            check("cmp_D_valid", D_valid, m_vvec());
            check("cmp_D0", D0, m_d[0]);
            check("cmp_D1", D1, m_d[1]);
            check("cmp_D2", D2, m_d[2]);
            check("cmp_D3", D3, m_d[3]);
            check("cmp_frame_done", frame_done, m_fd);
            check("cmp_sync_err", sync_err, m_se);
            if (frame_done) fd_count++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns 1 time unit after the edge that took it.
    task automatic send(input logic sof, input logic [WIDTH-1:0] d);
        bit done = 0;
        in_valid = 1'b1; in_sof = sof; in_data = d;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0; in_sof = 1'b0;
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: beat %0h never accepted", d);
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] a, b, c, d);
        send(1'b1, a); send(1'b0, b); send(1'b0, c); send(1'b0, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1 reset
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; started = 1'b1;
        #3;
        check("rst_S", S, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_locked", locked, 0);
        check("rst_D_valid", D_valid, 0);
        check("rst_D0", D0, 0);

        // 2 lock and deliver
        send_frame(4'hF, 4'h0, 4'h0, 4'h0);
        #3 check("lock_not_yet", locked, 0);
        send_frame(4'hA, 4'h5, 4'hC, 4'h3);
        #3 check("lock_after_f2", locked, 1);
        send(1'b1, 4'hC); #3 check("f3_D0", D0, 4'hC); check("f3_v0", D_valid[0], 1);
        send(1'b0, 4'h6); #3 check("f3_D1", D1, 4'h6);
        send(1'b0, 4'h3); #3 check("f3_D2", D2, 4'h3);
        send(1'b0, 4'h9); #3 check("f3_D3", D3, 4'h9); check("f3_fd", frame_done, 1);
        repeat (2) @(negedge clk);
        #1 check("frame_done_once", fd_count, 1);

        // 3 backpressure on channel 1
        sync();
        D_ready = 4'b1101;
        send_frame(4'h1, 4'h2, 4'h3, 4'h4);
        #3 check("bp_d1_held", D_valid[1], 1);
        send(1'b1, 4'h5);
        in_valid = 1'b1; in_sof = 1'b0; in_data = 4'h6;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", in_ready, 0);
            check("bp_stall_S", S, 1);
            check("bp_d1_old", D1, 4'h2);
        end
        sync();
        D_ready = 4'hF;
        send(1'b0, 4'h6);
        #3 check("bp_d1_new", D1, 4'h6); check("bp_d1_valid", D_valid[1], 1);
        send(1'b0, 4'h7);
        send(1'b0, 4'h8);

        // 4 sync loss: sof on slot 2
        repeat (2) sync();
        D_ready = 4'h0;
        send(1'b1, 4'h9);
        send(1'b0, 4'hA);
        #3 check("sl_pre_valid", D_valid, 4'b0011);
        send(1'b1, 4'hB);
        #3;
        check("sl_sync_err", sync_err, 1);
        check("sl_locked", locked, 0);
        check("sl_S", S, 0);
        check("sl_D2", D2, 4'h7);
        check("sl_valid_held", D_valid, 4'b0011);
        sync();
        #3 check("sl_pulse_end", sync_err, 0);

        // 5 abort in CHECK, then relock from scratch
        D_ready = 4'hF;
        send_frame(4'h1, 4'h2, 4'h3, 4'h4);
        send(1'b0, 4'h5);
        #3;
        check("ab_locked", locked, 0);
        check("ab_S", S, 0);
        check("ab_valid", D_valid, 0);
        send_frame(4'h1, 4'h2, 4'h3, 4'h4);
        #3 check("ab_one_frame", locked, 0);
        send_frame(4'h5, 4'h6, 4'h7, 4'h8);
        #3 check("ab_relocked", locked, 1);

        // 6 reset mid-frame
        sync();
        D_ready = 4'h0;
        send(1'b1, 4'hC);
        send(1'b0, 4'hD);
        #3;
        check("rm_pre_S", S, 2);
        check("rm_pre_valid", D_valid, 4'b0011);
        rst = 1'b1;
        @(posedge clk);
        #3;
        check("rm_valid", D_valid, 0);
        check("rm_S", S, 0);
        check("rm_locked", locked, 0);
        check("rm_in_ready", in_ready, 1);
        sync();
        rst = 1'b0;
        repeat (3) sync();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
